// File: rtl/max_pool_ctrl_if.sv
// Scheduler handshake, feature-map memory ports and pool-unit link of one max_pool_ctrl.
// Signal names keep the controller's point of view; the slave modport is the environment side.
interface max_pool_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 10
);
  logic                      start_i;
  logic [DIM_WIDTH-1:0]      width_i;
  logic [DIM_WIDTH-1:0]      height_i;
  logic [ADDR_WIDTH-1:0]     src_base_i;
  logic [ADDR_WIDTH-1:0]     dst_base_i;
  logic                      busy_o;
  logic                      done_o;
  logic                      rd_en_o;
  logic [ADDR_WIDTH-1:0]     rd_addr_o;
  logic [DATA_WIDTH-1:0]     rd_data_i;
  logic [4*DATA_WIDTH-1:0]   window_o;
  logic [DATA_WIDTH-1:0]     pool_i;
  logic                      wr_en_o;
  logic [ADDR_WIDTH-1:0]     wr_addr_o;
  logic [DATA_WIDTH-1:0]     wr_data_o;
  logic                      wr_ready_i;

  modport master (
    input  start_i, width_i, height_i, src_base_i, dst_base_i, rd_data_i, pool_i, wr_ready_i,
    output busy_o, done_o, rd_en_o, rd_addr_o, window_o, wr_en_o, wr_addr_o, wr_data_o
  );

  modport slave (
    output start_i, width_i, height_i, src_base_i, dst_base_i, rd_data_i, pool_i, wr_ready_i,
    input  busy_o, done_o, rd_en_o, rd_addr_o, window_o, wr_en_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/max_pool_ctrl.sv
// Walks a feature map in 2x2/stride-2 windows: four reads, one capture cycle, one pooled write.
// Window addresses come from row-base accumulators, so no multiplier is needed.
module max_pool_ctrl #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DIM_WIDTH  = 10
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  max_pool_ctrl_if.master bus
);
  typedef enum logic [2:0] {StIdle, StRead, StCapt, StWrite, StDone} state_e;

  state_e                     state_q, state_d;
  logic [1:0]                 k_q, k_d;
  logic [DIM_WIDTH-1:0]       ox_q, ox_d, oy_q, oy_d;
  logic [DIM_WIDTH-1:0]       ow_q, ow_d, oh_q, oh_d;
  logic [ADDR_WIDTH-1:0]      width_q, width_d;
  logic [ADDR_WIDTH-1:0]      row_q, row_d;  // address of window (0, oy)
  logic [ADDR_WIDTH-1:0]      win_q, win_d;  // address of window (ox, oy)
  logic [ADDR_WIDTH-1:0]      dst_q, dst_d;
  logic [3:0][DATA_WIDTH-1:0] window_q, window_d;
  logic                       last_col, last_win;

  assign bus.window_o = window_q;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    ox_d     = ox_q;
    oy_d     = oy_q;
    ow_d     = ow_q;
    oh_d     = oh_q;
    width_d  = width_q;
    row_d    = row_q;
    win_d    = win_q;
    dst_d    = dst_q;
    window_d = window_q;

    bus.busy_o    = 1'b0;
    bus.done_o    = 1'b0;
    bus.rd_en_o   = 1'b0;
    bus.rd_addr_o = '0;
    bus.wr_en_o   = 1'b0;
    bus.wr_addr_o = '0;
    bus.wr_data_o = '0;

    last_col = (ox_q == ow_q - 1'b1);
    last_win = last_col && (oy_q == oh_q - 1'b1);

    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          width_d = ADDR_WIDTH'(bus.width_i);
          ow_d    = bus.width_i >> 1;
          oh_d    = bus.height_i >> 1;
          row_d   = bus.src_base_i;
          win_d   = bus.src_base_i;
          dst_d   = bus.dst_base_i;
          ox_d    = '0;
          oy_d    = '0;
          k_d     = '0;
          if (bus.width_i < DIM_WIDTH'(2) || bus.height_i < DIM_WIDTH'(2)) begin
            state_d = StDone;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        bus.busy_o  = 1'b1;
        bus.rd_en_o = 1'b1;
        unique case (k_q)
          2'd0:    bus.rd_addr_o = win_q;
          2'd1:    bus.rd_addr_o = win_q + 1'b1;
          2'd2:    bus.rd_addr_o = win_q + width_q;
          default: bus.rd_addr_o = win_q + width_q + 1'b1;
        endcase
        // Read data trails its strobe by one cycle, so slice k-1 lands during read k.
        if (k_q != 2'd0) window_d[k_q - 2'd1] = bus.rd_data_i;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) state_d = StCapt;
      end
      StCapt: begin
        bus.busy_o  = 1'b1;
        window_d[3] = bus.rd_data_i;
        state_d     = StWrite;
      end
      StWrite: begin
        bus.busy_o    = 1'b1;
        bus.wr_en_o   = 1'b1;
        bus.wr_addr_o = dst_q;
        bus.wr_data_o = bus.pool_i;
        if (bus.wr_ready_i) begin
          dst_d = dst_q + 1'b1;
          if (last_col) begin
            ox_d  = '0;
            oy_d  = oy_q + 1'b1;
            row_d = row_q + (width_q << 1);
            win_d = row_q + (width_q << 1);
          end else begin
            ox_d  = ox_q + 1'b1;
            win_d = win_q + ADDR_WIDTH'(2);
          end
          state_d = last_win ? StDone : StRead;
        end
      end
      StDone: begin
        bus.done_o = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      k_q      <= '0;
      ox_q     <= '0;
      oy_q     <= '0;
      ow_q     <= '0;
      oh_q     <= '0;
      width_q  <= '0;
      row_q    <= '0;
      win_q    <= '0;
      dst_q    <= '0;
      window_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      ox_q     <= ox_d;
      oy_q     <= oy_d;
      ow_q     <= ow_d;
      oh_q     <= oh_d;
      width_q  <= width_d;
      row_q    <= row_d;
      win_q    <= win_d;
      dst_q    <= dst_d;
      window_q <= window_d;
    end
  end
endmodule

// File: doc/max_pool_ctrl.md
Name: max_pool_ctrl

Overview:
- Sequences a 2x2/stride-2 combinational max-pool unit over one feature map held in a shared single-port-read memory.
- Fetches the 4 pixels of each window and presents them to the pool unit as a packed window bus.
- Writes each pooled result to a destination region in row-major order.
- Sits between the layer scheduler (start/done) and the feature-map memories; one pool unit per controller.

Parameters:
- DATA_WIDTH, 32, signed pixel width; matches the pool unit.
- ADDR_WIDTH, 16, word-address width of source and destination memories.
- DIM_WIDTH, 10, width of the runtime map width/height fields.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse; latches config when idle.
- width_i  in  DIM_WIDTH  input map width W (pixels).
- height_i  in  DIM_WIDTH  input map height H (rows).
- src_base_i  in  ADDR_WIDTH  word address of pixel (0,0).
- dst_base_i  in  ADDR_WIDTH  word address of first output.
- busy_o  out  1  high from accepted start until done.
- done_o  out  1  one-cycle pulse after last write, or after a degenerate start.
- rd_en_o  out  1  memory read strobe.
- rd_addr_o  out  ADDR_WIDTH  read address.
- rd_data_i  in  DATA_WIDTH  read data; valid exactly 1 cycle after rd_en_o.
- window_o  out  4*DATA_WIDTH  to pool unit; slice k = bits [k*DATA_WIDTH +: DATA_WIDTH], order TL, TR, BL, BR.
- pool_i  in  DATA_WIDTH  pool unit result (combinational from window_o).
- wr_en_o  out  1  write request.
- wr_addr_o  out  ADDR_WIDTH  write address.
- wr_data_o  out  DATA_WIDTH  equals pool_i while wr_en_o high.
- wr_ready_i  in  1  write accepted when wr_en_o && wr_ready_i.

Behaviour:
- Reset (async, rst_ni low): state IDLE; busy_o, done_o, rd_en_o, wr_en_o = 0; rd_addr_o, wr_addr_o, window_o = 0; all counters = 0. Release is synchronous to clk_i.
- Config: width_i, height_i, src_base_i, dst_base_i sampled only on the cycle start_i is accepted (IDLE && start_i). start_i is ignored while busy_o = 1.
- Output size: OW = floor(W/2), OH = floor(H/2). For odd W or H, the last column/row is ignored.
- Degenerate map (W < 2 or H < 2): IDLE -> DONE; done_o pulses the next cycle. No memory access occurs.
- Window (ox, oy) base address: A = src_base + 2*oy*W + 2*ox. Address arithmetic is modulo 2^ADDR_WIDTH (wraps, no error). Keep row-base accumulators; no multiplier.
- States: IDLE, READ, CAPT, WRITE, DONE.
  - READ, 4 cycles, k = 0..3: rd_en_o = 1, rd_addr_o = A, A+1, A+W, A+W+1.
  - Data for read k is captured into window slice k one cycle later. Slice 0..2 are captured during READ cycles 1..3; slice 3 is captured in CAPT.
  - WRITE: wr_en_o = 1, wr_addr_o = dst_base + oy*OW + ox, wr_data_o = pool_i. Hold all signals while wr_ready_i = 0.
  - On the accepting cycle: advance ox; at ox = OW-1, wrap ox to 0 and increment oy. The next state is READ, or DONE after window (OW-1, OH-1).
  - DONE: done_o = 1 for one cycle, busy_o falls in the same cycle, then IDLE.
- busy_o = 1 in READ, CAPT and WRITE; 0 in IDLE and DONE.
- Throughput: 6 cycles per window with wr_ready_i tied high. Total time from start to done_o = 6*OW*OH + 1 cycles.
- window_o is stable through WRITE. It is not cleared between windows.
- rd_en_o and wr_en_o are never high in the same cycle.
- Reset mid-operation: all activity aborts immediately, no done_o is produced, and the controller returns to IDLE.

Test Plan:
- 4x4 map, src 0x100 = [1..16] row-major, dst 0x200, wr_ready = 1 -> writes 6, 8, 14, 16 at 0x200..0x203; done_o at cycle 25 after start.
- 5x3 map of signed values including negatives (-7 max in one window) -> OW = 2, OH = 1; exactly 2 writes; reads never touch column 4 or row 2; the -7 window writes -7.
- wr_ready_i low for 5 cycles on the 2nd write of the 4x4 case -> wr_en_o/addr/data held constant; results and order unchanged; done delayed 5 cycles.
- W = 1, H = 8 -> no rd_en_o or wr_en_o; done_o pulses 1 cycle after start; busy_o stays 0.
- start_i re-pulsed with different config mid-run -> ignored; original outputs unchanged.
- rst_ni asserted during WRITE -> all outputs 0 immediately; no done_o; a new start afterwards runs the 4x4 case correctly.
- src_base = 0xFFFE, ADDR_WIDTH = 16, 2x2 map -> read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
